// File: rtl/tempsense_pkg.sv
// Shared types and helpers for the delay-based temperature sensor controller.
package tempsense_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_TRANS = 3'd2,
        S_MEAS  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic int calc_ch_w(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [31:0] vmax(input int n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    endfunction

    function automatic logic [31:0] vmin();
        return 32'd0;
    endfunction

endpackage

// File: rtl/tempsense_sync.sv
// Two-flop synchroniser for one sensor output, followed by a rising-edge detector.
module tempsense_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_rise
);

    logic r_s1, r_s2, r_s3;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // A line already high before measurement never yields a pulse here.
    assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/tempsense_ctrl.sv
// Sequences sensor channels through precharge/transition/measure and digitises
// the sensor delay as a saturating cycle count.
module tempsense_ctrl
    import tempsense_pkg::*;
#(
    parameter int N_VDAC = 5,
    parameter int N_CH   = 2,
    parameter int CNT_W  = 12,
    parameter int PH_W   = 4,
    parameter int CH_W   = calc_ch_w(N_CH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic              i_continuous,
    input  logic [CH_W-1:0]   i_ch_sel,
    input  logic [N_VDAC-1:0] i_dac_cfg,
    input  logic [PH_W-1:0]   i_pre_cycles,
    input  logic [PH_W-1:0]   i_trans_cycles,
    input  logic              i_quick_transition,
    input  logic [N_CH-1:0]   i_tempdelay,
    output logic [N_VDAC-1:0] o_dac_data,
    output logic [N_CH-1:0]   o_dac_en,
    output logic [N_CH-1:0]   o_precharge_n,
    output logic [CNT_W-1:0]  o_result,
    output logic [CH_W-1:0]   o_result_ch,
    output logic              o_valid,
    output logic              o_timeout,
    output logic              o_busy,
    output logic [2:0]        o_state
);

    localparam logic [N_VDAC-1:0] VMAX    = N_VDAC'(vmax(N_VDAC));
    localparam logic [N_VDAC-1:0] VMIN    = N_VDAC'(vmin());
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CH_W:0]     N_CH_V  = (CH_W+1)'(N_CH);
    localparam int                RW      = 2**CH_W;

    state_t             r_state, w_state_nxt;
    logic [CH_W-1:0]    r_ch, w_ch_nxt, w_ch_inc;
    logic [PH_W-1:0]    r_ph, w_ph_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [N_CH-1:0]    w_rise, w_oh_nxt, w_dac_en, w_pre_n;
    logic [RW-1:0]      w_rise_pad;
    logic [N_VDAC-1:0]  w_dac;
    logic               w_sel_ok;

    for (genvar g = 0; g < N_CH; g++) begin : g_sync
        tempsense_sync u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .i_async (i_tempdelay[g]),
            .o_rise  (w_rise[g])
        );
    end

    assign w_rise_pad = RW'(w_rise);
    assign w_sel_ok   = ({1'b0, i_ch_sel} < N_CH_V);
    assign w_ch_inc   = ({1'b0, r_ch} == N_CH_V - 1'b1) ? '0 : r_ch + 1'b1;
    assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    assign w_oh_nxt   = N_CH'(1) << w_ch_nxt;
    assign o_state    = r_state;

    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        w_ph_nxt    = r_ph;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: if (i_start) begin
                w_state_nxt = S_PRE;
                w_ch_nxt    = w_sel_ok ? i_ch_sel : '0;
                w_ph_nxt    = i_pre_cycles;
            end
            S_PRE: if (r_ph == '0) begin
                w_state_nxt = S_TRANS;
                w_ph_nxt    = i_trans_cycles;
                w_cnt_nxt   = '0;
            end else begin
                w_ph_nxt = r_ph - 1'b1;
            end
            S_TRANS: begin
                w_cnt_nxt = w_cnt_inc;
                if (r_ph == '0) w_state_nxt = S_MEAS;
                else            w_ph_nxt    = r_ph - 1'b1;
            end
            S_MEAS: begin
                w_cnt_nxt = w_cnt_inc;
                if (w_rise_pad[r_ch] || w_cnt_inc == CNT_MAX) w_state_nxt = S_DONE;
            end
            S_DONE: if (i_continuous) begin
                w_state_nxt = S_PRE;
                w_ch_nxt    = w_ch_inc;
                w_ph_nxt    = i_pre_cycles;
            end else begin
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with r_state.
    always_comb begin
        w_dac_en = '0;
        w_pre_n  = '0;
        w_dac    = VMAX;
        case (w_state_nxt)
            S_PRE, S_DONE: w_dac_en = w_oh_nxt;
            S_TRANS: begin
                w_dac_en = w_oh_nxt;
                w_pre_n  = w_oh_nxt;
                w_dac    = (i_quick_transition && r_state == S_TRANS) ? i_dac_cfg : VMIN;
            end
            S_MEAS: begin
                w_dac_en = w_oh_nxt;
                w_pre_n  = w_oh_nxt;
                w_dac    = i_dac_cfg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_ch          <= '0;
            r_ph          <= '0;
            r_cnt         <= '0;
            o_result      <= '0;
            o_result_ch   <= '0;
            o_timeout     <= 1'b0;
            o_valid       <= 1'b0;
            o_busy        <= 1'b0;
            o_dac_en      <= '0;
            o_precharge_n <= '0;
            o_dac_data    <= VMAX;
        end else begin
            r_state       <= w_state_nxt;
            r_ch          <= w_ch_nxt;
            r_ph          <= w_ph_nxt;
            r_cnt         <= w_cnt_nxt;
            o_valid       <= (w_state_nxt == S_DONE);
            o_busy        <= (w_state_nxt != S_IDLE);
            o_dac_en      <= w_dac_en;
            o_precharge_n <= w_pre_n;
            o_dac_data    <= w_dac;
            if (r_state == S_MEAS && w_state_nxt == S_DONE) begin
                o_result    <= w_cnt_inc;
                o_result_ch <= r_ch;
                o_timeout   <= (w_cnt_inc == CNT_MAX);
            end
        end
    end

endmodule

// File: tb/tb_tempsense_ctrl.sv
// Directed and randomised checks of tempsense_ctrl against a cycle-count model.
module tb_tempsense_ctrl;

    localparam int N_VDAC = 5;
    localparam int N_CH   = 3;
    localparam int CNT_W  = 4;
    localparam int PH_W   = 4;
    localparam int CH_W   = 2;
    localparam int CMAX   = 15;
    localparam logic [N_VDAC-1:0] VMAX = '1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              i_start = 1'b0;
    logic              i_continuous = 1'b0;
    logic [CH_W-1:0]   i_ch_sel = '0;
    logic [N_VDAC-1:0] i_dac_cfg = '0;
    logic [PH_W-1:0]   i_pre_cycles = '0;
    logic [PH_W-1:0]   i_trans_cycles = '0;
    logic              i_quick_transition = 1'b0;
    logic [N_CH-1:0]   i_tempdelay = '0;
    logic [N_VDAC-1:0] o_dac_data;
    logic [N_CH-1:0]   o_dac_en;
    logic [N_CH-1:0]   o_precharge_n;
    logic [CNT_W-1:0]  o_result;
    logic [CH_W-1:0]   o_result_ch;
    logic              o_valid;
    logic              o_timeout;
    logic              o_busy;
    logic [2:0]        o_state;

    int checks = 0;
    int failures = 0;

    tempsense_ctrl #(
        .N_VDAC(N_VDAC), .N_CH(N_CH), .CNT_W(CNT_W), .PH_W(PH_W), .CH_W(CH_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_continuous(i_continuous),
        .i_ch_sel(i_ch_sel), .i_dac_cfg(i_dac_cfg), .i_pre_cycles(i_pre_cycles),
        .i_trans_cycles(i_trans_cycles), .i_quick_transition(i_quick_transition),
        .i_tempdelay(i_tempdelay), .o_dac_data(o_dac_data), .o_dac_en(o_dac_en),
        .o_precharge_n(o_precharge_n), .o_result(o_result), .o_result_ch(o_result_ch),
        .o_valid(o_valid), .o_timeout(o_timeout), .o_busy(o_busy), .o_state(o_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Measure cycles and result from the phase rules: exit on the synchronised edge
    // (two cycles after the line rises) or when the count would reach all ones.
    function automatic void model(input int t, input int j, output int m, output int res);
        int m_to;
        m_to = (CMAX - t > 1) ? CMAX - t : 1;
        m    = (j > 0 && j + 2 <= m_to) ? j + 2 : m_to;
        res  = (t + m > CMAX) ? CMAX : t + m;
    endfunction

    task automatic chk_idle(input string t, input int res);
        chk({t, "_state"}, 32'(o_state), 0);
        chk({t, "_busy"}, 32'(o_busy), 0);
        chk({t, "_valid"}, 32'(o_valid), 0);
        chk({t, "_en"}, 32'(o_dac_en), 0);
        chk({t, "_pren"}, 32'(o_precharge_n), 0);
        chk({t, "_dac"}, 32'(o_dac_data), 32'(VMAX));
        if (res >= 0) chk({t, "_result"}, 32'(o_result), 32'(res));
    endtask

    task automatic chk_reset(input string t);
        chk_idle(t, 0);
        chk({t, "_rch"}, 32'(o_result_ch), 0);
        chk({t, "_tout"}, 32'(o_timeout), 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("idle_state", 32'(o_state), 0);
        end
    endtask

    task automatic run_meas(input string t, input int ch_sel, input int pre, input int trans,
                            input bit qt, input int j, input bit hold_start,
                            input bit pre_high, input int nmeas);
        int p, tt, m, res, d, ch;
        logic [N_VDAC-1:0] cfg;
        p   = pre + 1;
        tt  = trans + 1;
        ch  = (ch_sel >= N_CH) ? 0 : ch_sel;
        cfg = N_VDAC'($urandom);
        model(tt, pre_high ? 0 : j, m, res);
        d   = p + tt + m + 1;
        i_ch_sel = CH_W'(ch_sel);
        i_pre_cycles = PH_W'(pre);
        i_trans_cycles = PH_W'(trans);
        i_quick_transition = qt;
        i_dac_cfg = cfg;
        i_tempdelay = '0;
        i_continuous = (nmeas > 1);
        i_start = 1'b1;
        for (int n = 0; n < nmeas; n++) begin
            for (int k = 1; k <= d; k++) begin
                int es;
                logic [N_CH-1:0] oh;
                logic [N_VDAC-1:0] ed;
                tick();
                if (k <= p)               es = 1;
                else if (k <= p + tt)     es = 2;
                else if (k <= p + tt + m) es = 3;
                else                      es = 4;
                oh = N_CH'(1) << ch;
                if (es == 2)      ed = (qt && k > p + 1) ? cfg : '0;
                else if (es == 3) ed = cfg;
                else              ed = VMAX;
                chk({t, "_state"}, 32'(o_state), 32'(es));
                chk({t, "_en"}, 32'(o_dac_en), 32'(oh));
                chk({t, "_pren"}, 32'(o_precharge_n), (es == 2 || es == 3) ? 32'(oh) : 0);
                chk({t, "_dac"}, 32'(o_dac_data), 32'(ed));
                chk({t, "_valid"}, 32'(o_valid), (es == 4) ? 1 : 0);
                chk({t, "_busy"}, 32'(o_busy), 1);
                if (es == 4) begin
                    chk({t, "_result"}, 32'(o_result), 32'(res));
                    chk({t, "_rch"}, 32'(o_result_ch), 32'(ch));
                    chk({t, "_tout"}, 32'(o_timeout), (res == CMAX) ? 1 : 0);
                end
                if (!hold_start || k == d) i_start = 1'b0;
                if (k == 1 && n == nmeas - 1) i_continuous = 1'b0;
                if (k == 1 && pre_high) i_tempdelay[ch] = 1'b1;
                if (j > 0 && k == p + tt + j) i_tempdelay[ch] = 1'b1;
                if (k == d) i_tempdelay = '0;
            end
            ch = (ch + 1) % N_CH;
        end
        tick();
        chk_idle({t, "_end"}, res);
    endtask

    initial begin
        tick();
        chk_reset("por");
        tick();
        reset_n = 1'b1;
        idle(2);

        run_meas("single", 0, 2, 1, 1'b0, 5, 1'b0, 1'b0, 1);
        chk("single_nine", 32'(o_result), 9);
        idle(3);
        run_meas("timeout", 1, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1);
        chk("timeout_flag", 32'(o_timeout), 1);
        idle(3);
        run_meas("quick1", 0, 1, 3, 1'b1, 4, 1'b0, 1'b0, 1);
        idle(3);
        run_meas("quick0", 2, 1, 3, 1'b0, 4, 1'b0, 1'b0, 1);
        idle(3);
        run_meas("prehigh", 1, 2, 1, 1'b0, 0, 1'b0, 1'b1, 1);
        idle(3);
        run_meas("hold", 2, 1, 1, 1'b0, 3, 1'b1, 1'b0, 1);
        idle(3);
        run_meas("cont", 2, 1, 2, 1'b0, 0, 1'b0, 1'b0, 4);
        idle(3);
        run_meas("cont_edge", 2, 0, 1, 1'b1, 2, 1'b0, 1'b0, 4);
        idle(3);
        run_meas("chsel_oor", 3, 0, 0, 1'b0, 1, 1'b0, 1'b0, 1);
        idle(3);

        // Reset in the middle of MEASURE: outputs clear at once, no strobe follows.
        i_ch_sel = 2'd1; i_pre_cycles = 4'd1; i_trans_cycles = 4'd1;
        i_continuous = 1'b1; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("rst_pre_state", 32'(o_state), 3);
        reset_n = 1'b0;
        #1;
        chk_reset("rst_async");
        i_continuous = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("rst_novalid", 32'(o_valid), 0);
            chk("rst_idle", 32'(o_state), 0);
        end

        for (int r = 0; r < 10; r++) begin
            run_meas("rand", $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 15),
                     1'($urandom_range(0, 1)), $urandom_range(0, 10), 1'b0, 1'b0,
                     $urandom_range(1, 2));
            idle(3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
